mips_gpio_port: RTL

Parametrised memory-mapped general-purpose I/O port for the pipelined MIPS processor. It replaces the fixed 8-bit input / 32-bit output port pair with configurable widths, input synchronisation, per-bit edge detection, a maskable interrupt and atomic set/clear/toggle writes. It sits on the data-memory bus beside data RAM and is selected by address decode inside the block.

---
 rtl/mips_gpio_pkg.sv | 20 ++
 rtl/mips_gpio_port_sync.sv | 26 ++
 rtl/mips_gpio_port.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mips_gpio_pkg.sv
// Register offsets and edge-mode encodings shared by the GPIO port.
package mips_gpio_pkg;

   localparam logic [4:0] GPIO_DATA_OUT    = 5'h00;
   localparam logic [4:0] GPIO_DATA_IN     = 5'h04;
   localparam logic [4:0] GPIO_EDGE_STATUS = 5'h08;
   localparam logic [4:0] GPIO_IRQ_MASK    = 5'h0C;
   localparam logic [4:0] GPIO_EDGE_MODE   = 5'h10;
   localparam logic [4:0] GPIO_OUT_SET     = 5'h14;
   localparam logic [4:0] GPIO_OUT_CLR     = 5'h18;
   localparam logic [4:0] GPIO_OUT_TOG     = 5'h1C;

   typedef enum logic [1:0] {
      EDGE_RISE = 2'b00,
      EDGE_FALL = 2'b01,
      EDGE_BOTH = 2'b10,
      EDGE_OFF  = 2'b11
   } edge_mode_t;

endpackage

// File: rtl/mips_gpio_port_sync.sv
// Multi-stage input synchroniser; a port_in change reaches o_q after STAGES edges.
// No flow control: samples every clock.
module gpio_sync #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_stage [STAGES];

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
      end else begin
         r_stage[0] <= i_d;
         for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
      end
   end

   assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/mips_gpio_port.sv
// Memory-mapped GPIO: output register with set/clr/toggle, synchronised inputs, edge status, maskable irq.
// Writes take effect at the selecting edge; reads are combinational; the bus never stalls.
module mips_gpio_port
   import mips_gpio_pkg::*;
#(
   parameter int                   IN_WIDTH    = 8,
   parameter int                   OUT_WIDTH   = 32,
   parameter logic [31:0]          BASE_ADDR   = 32'h1001_0020,
   parameter int                   SYNC_STAGES = 2,
   parameter logic [OUT_WIDTH-1:0] RESET_OUT   = '0
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_mem_write,
   input  logic                 i_mem_read,
   input  logic [31:0]          i_address,
   input  logic [31:0]          i_write_data,
   output logic [31:0]          o_read_data,
   input  logic [IN_WIDTH-1:0]  i_port_in,
   output logic [OUT_WIDTH-1:0] o_port_out,
   output logic                 o_irq
);

   localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

   logic                 w_sel;
   logic                 w_wr;
   logic [4:0]           w_off;
   logic [OUT_WIDTH-1:0] w_wd_out;
   logic [IN_WIDTH-1:0]  w_wd_in;
   logic [IN_WIDTH-1:0]  w_sync;
   logic [IN_WIDTH-1:0]  w_det;
   logic [IN_WIDTH-1:0]  w_w1c;
   logic                 w_armed;

   logic [OUT_WIDTH-1:0] r_out;
   logic [IN_WIDTH-1:0]  r_prev;
   logic [IN_WIDTH-1:0]  r_status;
   logic [IN_WIDTH-1:0]  r_mask;
   edge_mode_t           r_mode;
   logic [2:0]           r_arm;

   assign w_sel    = (i_address[31:5] == BASE_ADDR[31:5]);
   assign w_off    = i_address[4:0] & 5'b11100;
   assign w_wr     = i_mem_write & w_sel;
   assign w_wd_out = i_write_data[OUT_WIDTH-1:0];
   assign w_wd_in  = i_write_data[IN_WIDTH-1:0];
   assign w_w1c    = (w_wr && (w_off == GPIO_EDGE_STATUS)) ? w_wd_in : '0;
   assign w_armed  = (r_arm == ARM_MAX);

   gpio_sync #(
      .WIDTH  (IN_WIDTH),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_d     (i_port_in),
      .o_q     (w_sync)
   );

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_out <= RESET_OUT;
      end else if (w_wr) begin
         case (w_off)
            GPIO_DATA_OUT: r_out <= w_wd_out;
            GPIO_OUT_SET:  r_out <= r_out | w_wd_out;
            GPIO_OUT_CLR:  r_out <= r_out & ~w_wd_out;
            GPIO_OUT_TOG:  r_out <= r_out ^ w_wd_out;
            default:       ;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_mask <= '0;
         r_mode <= EDGE_RISE;
      end else if (w_wr) begin
         if (w_off == GPIO_IRQ_MASK)  r_mask <= w_wd_in;
         if (w_off == GPIO_EDGE_MODE) r_mode <= edge_mode_t'(i_write_data[1:0]);
      end
   end

   // Arming holds off detection until the synchroniser and delayed copy hold real samples.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_arm <= 3'd0;
      end else if (!w_armed) begin
         r_arm <= r_arm + 3'd1;
      end
   end

   always_comb begin
      w_det = '0;
      if (w_armed) begin
         case (r_mode)
            EDGE_RISE: w_det = w_sync & ~r_prev;
            EDGE_FALL: w_det = ~w_sync & r_prev;
            EDGE_BOTH: w_det = w_sync ^ r_prev;
            default:   w_det = '0;
         endcase
      end
   end

   // Set is OR-ed in after the clear so a coincident new edge survives the W1C.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_prev   <= '0;
         r_status <= '0;
      end else begin
         r_prev   <= w_sync;
         r_status <= (r_status & ~w_w1c) | w_det;
      end
   end

   always_comb begin
      o_read_data = '0;
      if (i_mem_read && w_sel) begin
         case (w_off)
            GPIO_DATA_OUT:    o_read_data[OUT_WIDTH-1:0] = r_out;
            GPIO_DATA_IN:     o_read_data[IN_WIDTH-1:0]  = w_sync;
            GPIO_EDGE_STATUS: o_read_data[IN_WIDTH-1:0]  = r_status;
            GPIO_IRQ_MASK:    o_read_data[IN_WIDTH-1:0]  = r_mask;
            GPIO_EDGE_MODE:   o_read_data[1:0]           = r_mode;
            default:          ;
         endcase
      end
   end

   assign o_port_out = r_out;
   assign o_irq      = |(r_status & r_mask);

endmodule
